piksel_akis_besleyici: RTL and testbench

- Upstream feeder for the image-processing stage.
- Reads a grayscale frame of S pixels from a synchronous single-port RAM with 1-cycle read latency, addresses 0..S-1.
- Streams the pixels in order over a valid/ready handshake to the processing module's `veri_i` input.
- A 2-entry output buffer absorbs RAM latency under backpressure, so no pixel is dropped or duplicated, and throughput is 1 pixel/cycle while the consumer is ready.

---
 rtl/piksel_akis_besleyici.sv | 130 +++++++++++++
 tb/tb_piksel_akis_besleyici.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piksel_akis_besleyici.sv
// Frame feeder: reads S pixels from a 1-cycle-latency RAM and streams them
// over valid/ready through a 2-entry buffer, credit-limited so nothing drops.
module piksel_akis_besleyici #(
  parameter int V = 8,
  parameter int S = 76800,
  parameter int A = 17
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         bas_i,
  output logic         ram_en_o,
  output logic [A-1:0] ram_addr_o,
  input  logic [V-1:0] ram_data_i,
  output logic [V-1:0] veri_o,
  output logic         veri_gecerli_o,
  input  logic         veri_al_i,
  output logic         son_o,
  output logic         mesgul_o,
  output logic         bitti_o
);

  typedef enum logic [1:0] {BOSTA, OKU, BOSALT, BITTI} durum_e;

  localparam logic [A-1:0] SON_ADR = A'(S - 1);

  durum_e         durum_q, durum_d;
  logic [A-1:0]   oku_q, oku_d;
  logic [A-1:0]   akt_q, akt_d;
  logic [V-1:0]   tam0_q, tam0_d;
  logic [V-1:0]   tam1_q, tam1_d;
  logic [1:0]     dol_q, dol_d;
  logic           bek_q, bek_d;
  logic           aktar;
  logic           kredi_ok;
  logic           oku_ver;

  assign veri_gecerli_o = (dol_q != 2'd0);
  assign veri_o         = tam0_q;
  assign ram_addr_o     = oku_q;
  assign son_o          = veri_gecerli_o & (akt_q == SON_ADR);
  assign aktar          = veri_gecerli_o & veri_al_i;

  // Buffered + in-flight entries after this cycle's pop must leave room for one more.
  assign kredi_ok = ({1'b0, dol_q} + {2'b00, bek_q}) <= (3'd1 + {2'b00, aktar});
  assign oku_ver  = (durum_q == OKU) && kredi_ok;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q <= BOSTA;
      oku_q   <= '0;
      akt_q   <= '0;
      tam0_q  <= '0;
      tam1_q  <= '0;
      dol_q   <= 2'd0;
      bek_q   <= 1'b0;
    end else begin
      durum_q <= durum_d;
      oku_q   <= oku_d;
      akt_q   <= akt_d;
      tam0_q  <= tam0_d;
      tam1_q  <= tam1_d;
      dol_q   <= dol_d;
      bek_q   <= bek_d;
    end
  end

  // The last issue moves to BOSALT directly, so the read counter never needs to hold S.
  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOSTA:   if (bas_i) durum_d = OKU;
      OKU:     if (oku_ver && (oku_q == SON_ADR)) durum_d = BOSALT;
      BOSALT:  if (aktar && (akt_q == SON_ADR)) durum_d = BITTI;
      BITTI:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_comb begin
    ram_en_o = 1'b0;
    mesgul_o = 1'b0;
    bitti_o  = 1'b0;
    case (durum_q)
      OKU: begin
        mesgul_o = 1'b1;
        ram_en_o = oku_ver;
      end
      BOSALT:  mesgul_o = 1'b1;
      BITTI:   bitti_o  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    oku_d  = oku_q;
    akt_d  = akt_q;
    tam0_d = tam0_q;
    tam1_d = tam1_q;
    dol_d  = dol_q;
    bek_d  = oku_ver;
    if ((durum_q == BOSTA) && bas_i) begin
      oku_d = '0;
      akt_d = '0;
    end
    if (oku_ver) oku_d = oku_q + 1'b1;
    if (aktar)   akt_d = akt_q + 1'b1;
    // tam0 is always the head; push lands behind whatever survives the pop.
    case ({bek_q, aktar})
      2'b10: begin
        if (dol_q == 2'd0) tam0_d = ram_data_i;
        else               tam1_d = ram_data_i;
        dol_d = dol_q + 2'd1;
      end
      2'b01: begin
        tam0_d = tam1_q;
        dol_d  = dol_q - 2'd1;
      end
      2'b11: begin
        if (dol_q == 2'd1) begin
          tam0_d = ram_data_i;
        end else begin
          tam0_d = tam1_q;
          tam1_d = ram_data_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piksel_akis_besleyici.sv
// Scoreboard bench: frames queue their expected pixels, negedge monitors pop
// and compare on every transfer. Second instance uses S == 2^A.
module tb_piksel_akis_besleyici;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bas, al;
  logic       ram_en;
  logic [4:0] ram_addr;
  logic [7:0] ram_data;
  logic [7:0] veri;
  logic       gec, son, mesgul, bitti;

  logic       bas_b, al_b;
  logic       ram_en_b;
  logic [4:0] ram_addr_b;
  logic [7:0] ram_data_b;
  logic [7:0] veri_b;
  logic       gec_b, son_b, mesgul_b, bitti_b;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int acc_edge, last_edge, bitti_edge;
  int acc_b, last_b, n_iss_b;
  int n_iss, n_xfer, max_out;
  logic [4:0] exp_addr;
  logic [8:0] q_exp[$];
  logic [8:0] q_b[$];
  logic prev_stall, prev_bitti;
  logic [7:0] prev_veri;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piksel_akis_besleyici #(.V(8), .S(16), .A(5)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .bas_i(bas),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_data_i(ram_data),
    .veri_o(veri), .veri_gecerli_o(gec), .veri_al_i(al),
    .son_o(son), .mesgul_o(mesgul), .bitti_o(bitti));

  piksel_akis_besleyici #(.V(8), .S(32), .A(5)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .bas_i(bas_b),
    .ram_en_o(ram_en_b), .ram_addr_o(ram_addr_b), .ram_data_i(ram_data_b),
    .veri_o(veri_b), .veri_gecerli_o(gec_b), .veri_al_i(al_b),
    .son_o(son_b), .mesgul_o(mesgul_b), .bitti_o(bitti_b));

  always @(posedge clk) begin
    if (ram_en)   ram_data   <= 8'(ram_addr) + 8'h10;
    if (ram_en_b) ram_data_b <= 8'(ram_addr_b) + 8'h10;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor for the S=16 instance.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_bitti = 1'b0;
      n_iss      = 0;
      n_xfer     = 0;
    end else begin
      if (n_iss - n_xfer > max_out) max_out = n_iss - n_xfer;
      if (ram_en) begin
        chk("adres", 32'(ram_addr), 32'(exp_addr));
        exp_addr = exp_addr + 5'd1;
        n_iss++;
      end
      if (prev_stall) begin
        chk("tutma_gecerli", 32'(gec), 32'd1);
        chk("tutma_veri", 32'(veri), 32'(prev_veri));
      end
      if (son && !gec) chk("son_gecersiz", 32'(son), 32'd0);
      if (gec && al) begin
        if (q_exp.size() == 0) begin
          chk("fazla_cikis", 32'd1, 32'd0);
        end else begin
          e = q_exp.pop_front();
          chk("veri", 32'(veri), 32'(e[7:0]));
          chk("son", 32'(son), 32'(e[8]));
        end
        n_xfer++;
        last_edge = cyc + 1;
      end
      if (bitti) begin
        chk("bitti_tek_darbe", 32'(prev_bitti), 32'd0);
        chk("bitti_mesgul", 32'(mesgul), 32'd0);
        bitti_edge = cyc;
      end
      prev_stall = gec && !al;
      prev_veri  = veri;
      prev_bitti = bitti;
    end
  end

  // Monitor for the S=32 instance.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n) begin
      if (ram_en_b) n_iss_b++;
      if (gec_b && al_b) begin
        if (q_b.size() == 0) begin
          chk("b_fazla_cikis", 32'd1, 32'd0);
        end else begin
          e = q_b.pop_front();
          chk("b_veri", 32'(veri_b), 32'(e[7:0]));
          chk("b_son", 32'(son_b), 32'(e[8]));
        end
        last_b = cyc + 1;
      end
    end
  end

  // Queues the 16 expected pixels and pulses bas for one cycle; returns at the
  // negedge after the acceptance edge.
  task automatic frame_start();
    @(posedge clk); #1;
    bas      = 1'b1;
    exp_addr = 5'd0;
    for (int i = 0; i < 16; i++) q_exp.push_back({(i == 15), 8'(i + 16)});
    @(posedge clk); #1;
    bas = 1'b0;
    @(negedge clk);
    acc_edge = cyc;
  endtask

  // Drives al from an 8-cycle pattern (msb first) until bitti is seen.
  task automatic run_until_done(input logic [7:0] pat, input int lim);
    logic seen = 1'b0;
    for (int k = 0; k < lim && !seen; k++) begin
      @(posedge clk); #1;
      al = pat[7 - (k % 8)];
      @(negedge clk);
      if (bitti) seen = 1'b1;
    end
    #1;
    chk("bitti_zaman_asimi", 32'(seen), 32'd1);
    chk("kuyruk_bos", 32'(q_exp.size()), 32'd0);
  endtask

  initial begin
    int cnt;
    logic seen;
    rst_n = 1'b0; bas = 1'b0; al = 1'b1; bas_b = 1'b0; al_b = 1'b1;
    max_out = 0; n_iss_b = 0; exp_addr = 5'd0;
    @(negedge clk);
    chk("reset_cikis", {16'd0, ram_en, ram_addr, veri, gec, son, mesgul, bitti}, 32'd0);
    chk("reset_cikis_b", {16'd0, ram_en_b, ram_addr_b, veri_b, gec_b, son_b, mesgul_b, bitti_b}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full-rate frame: latency, order, son, bitti timing.
    frame_start();
    chk("kabul_mesgul", 32'(mesgul), 32'd1);
    chk("kabul_okuma", 32'(ram_en), 32'd1);
    @(negedge clk);
    chk("e1_gecersiz", 32'(gec), 32'd0);
    @(negedge clk);
    chk("e2_gecerli", 32'(gec), 32'd1);
    chk("e2_veri", 32'(veri), 32'h10);
    run_until_done(8'hFF, 40);
    chk("son_aktarim_gecikme", 32'(last_edge - acc_edge), 32'd18);
    chk("bitti_kenari", 32'(bitti_edge), 32'(last_edge));

    // Irregular backpressure.
    frame_start();
    run_until_done(8'b1001_0110, 120);
    chk("doluluk_sinir", 32'(max_out <= 2), 32'd1);

    // Long stall right after start: only two reads may go out.
    al = 1'b0;
    frame_start();
    cnt = int'(ram_en);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      cnt += int'(ram_en);
    end
    chk("durak_okuma_sayisi", 32'(cnt), 32'd2);
    chk("durak_gecerli", 32'(gec), 32'd1);
    run_until_done(8'hFF, 60);

    // Asynchronous reset while pixel 7 is at the head.
    al = 1'b1;
    frame_start();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (q_exp.size() <= 9) break;
    end
    @(posedge clk); #2;
    chk("reset_oncesi_veri", 32'(veri), 32'h17);
    rst_n = 1'b0;
    #1;
    chk("asenkron_reset", {16'd0, ram_en, ram_addr, veri, gec, son, mesgul, bitti}, 32'd0);
    q_exp.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    frame_start();
    run_until_done(8'hFF, 40);
    chk("reset_sonrasi_gecikme", 32'(last_edge - acc_edge), 32'd18);

    // bas mid-frame is ignored; bas right after bitti starts the next frame.
    frame_start();
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    bas = 1'b1;
    @(posedge clk); #1;
    bas = 1'b0;
    run_until_done(8'hFF, 40);
    chk("orta_bas_gecikme", 32'(last_edge - acc_edge), 32'd18);
    frame_start();
    chk("ardisik_kabul", 32'(acc_edge), 32'(bitti_edge + 2));
    run_until_done(8'hFF, 40);
    chk("ardisik_gecikme", 32'(last_edge - acc_edge), 32'd18);
    chk("doluluk_son", 32'(max_out <= 2), 32'd1);

    // S == 2^A instance: 32 pixels, no read beyond the last address.
    @(posedge clk); #1;
    bas_b = 1'b1;
    for (int i = 0; i < 32; i++) q_b.push_back({(i == 31), 8'(i + 16)});
    @(posedge clk); #1;
    bas_b = 1'b0;
    @(negedge clk);
    acc_b = cyc;
    seen  = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (bitti_b) seen = 1'b1;
    end
    #1;
    chk("b_bitti", 32'(seen), 32'd1);
    chk("b_kuyruk_bos", 32'(q_b.size()), 32'd0);
    chk("b_okuma_sayisi", 32'(n_iss_b), 32'd32);
    chk("b_gecikme", 32'(last_b - acc_b), 32'd34);
    @(negedge clk);
    chk("b_bosta", {29'd0, mesgul_b, bitti_b, ram_en_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
